sprite_animator: RTL and testbench

- Parametrised sprite pixel engine for the fighter renderer.
- Stores any number of animation frames back-to-back in one external sprite ROM.
- Per pixel: bounding-box test, optional horizontal mirroring, ROM addressing, a writable colour palette and transparency keying.
- Advances animation frames on vertical-blank pulses in loop or one-shot mode; drives a compositor that layers sprites over the background.

---
 rtl/sprite_animator.sv | 191 +++++++++++++++++++
 tb/tb_sprite_animator.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_animator.sv
// Sprite pixel engine: bounding box, mirroring, ROM addressing, palette lookup and
// transparency keying with a fixed 3-cycle pixel latency, plus a frame-stepping animation FSM.
module sprite_animator #(
    parameter int SPR_W  = 64,
    parameter int SPR_H  = 96,
    parameter int FRAMES = 4,
    parameter int IDX_W  = 3,
    parameter int HOLD   = 6,
    parameter int X_W    = 10,
    parameter int ADDR_W = $clog2(FRAMES*SPR_W*SPR_H)
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic [X_W-1:0]    draw_x,
    input  logic [X_W-1:0]    draw_y,
    input  logic [X_W-1:0]    spr_x,
    input  logic [X_W-1:0]    spr_y,
    input  logic              flip_h,
    input  logic              play,
    input  logic              loop,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    input  logic              pal_we,
    input  logic [IDX_W-1:0]  pal_windex,
    input  logic [11:0]       pal_wdata,
    input  logic              blank,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              opaque
);
    // state  | meaning
    // S_IDLE | not animating, frame_idx holds its last value
    // S_PLAY | stepping frames every HOLD frame_start pulses
    typedef enum logic {S_IDLE = 1'b0, S_PLAY = 1'b1} state_t;

    localparam int FI_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int NPAL = 2**IDX_W;
    localparam logic [ADDR_W-1:0] FRAME_SZ   = ADDR_W'(SPR_W*SPR_H);
    localparam logic [ADDR_W-1:0] ROW_SZ     = ADDR_W'(SPR_W);
    localparam logic [FI_W-1:0]   LAST_FRAME = FI_W'(FRAMES-1);
    localparam logic [HC_W-1:0]   LAST_HOLD  = HC_W'(HOLD-1);
    localparam logic [X_W:0]      W_LIM      = (X_W+1)'(SPR_W);
    localparam logic [X_W:0]      H_LIM      = (X_W+1)'(SPR_H);
    localparam logic [X_W:0]      W_M1       = (X_W+1)'(SPR_W-1);

    state_t          state_q, state_d;
    logic [FI_W-1:0] frame_q, frame_d;
    logic [HC_W-1:0] hold_q, hold_d;
    logic            loop_q, loop_d;
    logic            done_q, done_d;

    logic [X_W-1:0]  sx_q, sx_d, sy_q, sy_d;
    logic            flip_q, flip_d;

    logic [NPAL-1:0][11:0] pal_q, pal_d;

    logic [X_W:0]      dx, dy, col;
    logic              in_box;
    logic [ADDR_W-1:0] rom_address_q, rom_address_d;
    logic              box1_q, box1_d, blank1_q, blank1_d;
    logic              box2_q, box2_d, blank2_q, blank2_d;
    logic [11:0]       rgb_q, rgb_d;
    logic              opaque_q, opaque_d;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            frame_q <= '0;
            hold_q  <= '0;
            loop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            hold_q  <= hold_d;
            loop_q  <= loop_d;
            done_q  <= done_d;
        end
    end

    // play has priority over frame_start so a restart never advances in the same cycle
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        hold_d  = hold_q;
        loop_d  = loop_q;
        done_d  = 1'b0;
        if (play) begin
            state_d = S_PLAY;
            frame_d = '0;
            hold_d  = '0;
            loop_d  = loop;
        end else if (state_q == S_PLAY && frame_start) begin
            if (hold_q != LAST_HOLD) begin
                hold_d = hold_q + 1'b1;
            end else begin
                hold_d = '0;
                if (frame_q != LAST_FRAME) begin
                    frame_d = frame_q + 1'b1;
                end else if (loop_q) begin
                    frame_d = '0;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy = (state_q == S_PLAY);
        done = done_q;
    end

    always_comb begin
        sx_d   = sx_q;
        sy_d   = sy_q;
        flip_d = flip_q;
        if (frame_start) begin
            sx_d   = spr_x;
            sy_d   = spr_y;
            flip_d = flip_h;
        end
        pal_d = pal_q;
        if (pal_we) begin
            pal_d[pal_windex] = pal_wdata;
        end
    end

    // one extra bit makes positions left of / above the sprite wrap high and fail the box test
    always_comb begin
        dx     = {1'b0, draw_x} - {1'b0, sx_q};
        dy     = {1'b0, draw_y} - {1'b0, sy_q};
        in_box = (dx < W_LIM) && (dy < H_LIM);
        col    = flip_q ? (W_M1 - dx) : dx;
        rom_address_d = '0;
        if (in_box) begin
            rom_address_d = ADDR_W'(frame_q) * FRAME_SZ + ADDR_W'(dy) * ROW_SZ + ADDR_W'(col);
        end
        box1_d   = in_box;
        blank1_d = blank;
        box2_d   = box1_q;
        blank2_d = blank1_q;
        rgb_d    = '0;
        opaque_d = 1'b0;
        if (blank2_q && box2_q && rom_q != '0) begin
            rgb_d    = pal_q[rom_q];
            opaque_d = 1'b1;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            sx_q          <= '0;
            sy_q          <= '0;
            flip_q        <= 1'b0;
            pal_q         <= '0;
            rom_address_q <= '0;
            box1_q        <= 1'b0;
            blank1_q      <= 1'b0;
            box2_q        <= 1'b0;
            blank2_q      <= 1'b0;
            rgb_q         <= '0;
            opaque_q      <= 1'b0;
        end else begin
            sx_q          <= sx_d;
            sy_q          <= sy_d;
            flip_q        <= flip_d;
            pal_q         <= pal_d;
            rom_address_q <= rom_address_d;
            box1_q        <= box1_d;
            blank1_q      <= blank1_d;
            box2_q        <= box2_d;
            blank2_q      <= blank2_d;
            rgb_q         <= rgb_d;
            opaque_q      <= opaque_d;
        end
    end

    assign rom_address = rom_address_q;
    assign red         = rgb_q[11:8];
    assign green       = rgb_q[7:4];
    assign blue        = rgb_q[3:0];
    assign opaque      = opaque_q;

endmodule

// File: tb/tb_sprite_animator.sv
// Bench for sprite_animator: random pixels and animation sequences against a
// pulse-counting animation model and an integer-arithmetic pixel model.
module tb_sprite_animator;
    localparam int SPR_W  = 64;
    localparam int SPR_H  = 96;
    localparam int FRAMES = 4;
    localparam int IDX_W  = 3;
    localparam int HOLD   = 6;
    localparam int X_W    = 10;
    localparam int ADDR_W = $clog2(FRAMES*SPR_W*SPR_H);
    localparam int FSZ    = SPR_W*SPR_H;

    logic              vga_clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              frame_start = 1'b0;
    logic [X_W-1:0]    draw_x = '0, draw_y = '0, spr_x = '0, spr_y = '0;
    logic              flip_h = 1'b0, play = 1'b0, loop = 1'b0;
    logic              busy, done;
    logic [ADDR_W-1:0] rom_address;
    logic [IDX_W-1:0]  rom_q = '0;
    logic              pal_we = 1'b0;
    logic [IDX_W-1:0]  pal_windex = '0;
    logic [11:0]       pal_wdata = '0;
    logic              blank = 1'b0;
    logic [3:0]        red, green, blue;
    logic              opaque;

    int n_vec = 0;
    int n_err = 0;

    logic [IDX_W-1:0] rom_mem [FRAMES*FSZ];
    logic [11:0]      m_pal [2**IDX_W];
    int               m_sx = 0, m_sy = 0, m_pulses = 0;
    bit               m_flip = 0, m_loop = 0, m_played = 0;
    int               q_x[$], q_y[$];
    bit               q_b[$];

    sprite_animator #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES), .IDX_W(IDX_W),
        .HOLD(HOLD), .X_W(X_W), .ADDR_W(ADDR_W)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .frame_start(frame_start),
        .draw_x(draw_x), .draw_y(draw_y), .spr_x(spr_x), .spr_y(spr_y),
        .flip_h(flip_h), .play(play), .loop(loop), .busy(busy), .done(done),
        .rom_address(rom_address), .rom_q(rom_q), .pal_we(pal_we),
        .pal_windex(pal_windex), .pal_wdata(pal_wdata), .blank(blank),
        .red(red), .green(green), .blue(blue), .opaque(opaque)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) rom_q <= rom_mem[rom_address];

    function automatic bit mdl_in_box(int x, int y);
        return x >= m_sx && x < m_sx + SPR_W && y >= m_sy && y < m_sy + SPR_H;
    endfunction

    function automatic bit exp_busy();
        return m_played && (m_loop || m_pulses < FRAMES*HOLD);
    endfunction

    function automatic int exp_frame();
        int f;
        if (!m_played) return 0;
        f = m_pulses / HOLD;
        if (m_loop) return f % FRAMES;
        return (f > FRAMES-1) ? FRAMES-1 : f;
    endfunction

    function automatic int exp_addr(int x, int y);
        int col;
        if (!mdl_in_box(x, y)) return 0;
        col = m_flip ? (m_sx + SPR_W - 1 - x) : (x - m_sx);
        return exp_frame()*FSZ + (y - m_sy)*SPR_W + col;
    endfunction

    function automatic logic [12:0] exp_pix(int x, int y, bit b);
        logic [IDX_W-1:0] idx;
        if (!(b && mdl_in_box(x, y))) return '0;
        idx = rom_mem[exp_addr(x, y)];
        if (idx == '0) return '0;
        return {1'b1, m_pal[idx]};
    endfunction

    task automatic add_pt(input int x, input int y, input bit b);
        q_x.push_back(x);
        q_y.push_back(y);
        q_b.push_back(b);
    endtask

    // streams queued beam positions one per cycle, checking address at +1 and colour at +3
    task automatic run_queue(input string tag);
        int          n;
        int          ea[$];
        logic [12:0] ep[$];
        n = q_x.size();
        for (int i = 0; i < n + 3; i++) begin
            @(negedge vga_clk);
            if (i >= 1 && i <= n) begin
                n_vec++;
                if (rom_address !== ADDR_W'(ea[i-1])) begin
                    n_err++;
                    $display("FAIL %s_addr[%0d]: got %0d expected %0d", tag, i-1, rom_address, ea[i-1]);
                end
            end
            if (i >= 3) begin
                n_vec++;
                if ({opaque, red, green, blue} !== ep[i-3]) begin
                    n_err++;
                    $display("FAIL %s_pix[%0d]: got %h expected %h", tag, i-3, {opaque, red, green, blue}, ep[i-3]);
                end
            end
            if (i < n) begin
                draw_x = X_W'(q_x[i]);
                draw_y = X_W'(q_y[i]);
                blank  = q_b[i];
                ea.push_back(exp_addr(q_x[i], q_y[i]));
                ep.push_back(exp_pix(q_x[i], q_y[i], q_b[i]));
            end else begin
                draw_x = '0;
                draw_y = '0;
                blank  = 1'b0;
            end
        end
        q_x.delete();
        q_y.delete();
        q_b.delete();
    endtask

    task automatic check_origin(input string tag);
        add_pt(m_sx, m_sy, 1'b1);
        run_queue(tag);
    endtask

    task automatic write_pal(input int idx, input logic [11:0] data);
        @(negedge vga_clk);
        pal_we = 1'b1;
        pal_windex = IDX_W'(idx);
        pal_wdata = data;
        @(negedge vga_clk);
        pal_we = 1'b0;
        m_pal[idx] = data;
    endtask

    task automatic frame_pulse(input int x, input int y, input bit fl);
        bit was_busy, exp_done;
        @(negedge vga_clk);
        spr_x = X_W'(x);
        spr_y = X_W'(y);
        flip_h = fl;
        frame_start = 1'b1;
        @(negedge vga_clk);
        frame_start = 1'b0;
        m_sx = x;
        m_sy = y;
        m_flip = fl;
        was_busy = exp_busy();
        if (was_busy) m_pulses++;
        exp_done = was_busy && !m_loop && m_pulses == FRAMES*HOLD;
        n_vec++;
        if (done !== exp_done) begin
            n_err++;
            $display("FAIL pulse_done: got %b expected %b (pulses %0d)", done, exp_done, m_pulses);
        end
        n_vec++;
        if (busy !== exp_busy()) begin
            n_err++;
            $display("FAIL pulse_busy: got %b expected %b (pulses %0d)", busy, exp_busy(), m_pulses);
        end
        @(negedge vga_clk);
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL done_width: got %b expected 0", done);
        end
    endtask

    task automatic do_play(input bit l, input bit fs);
        @(negedge vga_clk);
        play = 1'b1;
        loop = l;
        frame_start = fs;
        @(negedge vga_clk);
        play = 1'b0;
        frame_start = 1'b0;
        if (fs) begin
            m_sx = int'(spr_x);
            m_sy = int'(spr_y);
            m_flip = flip_h;
        end
        m_played = 1;
        m_pulses = 0;
        m_loop = l;
        n_vec++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL play_accept: got busy=%b done=%b expected busy=1 done=0", busy, done);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge vga_clk);
        n_vec++;
        if ({busy, done, opaque, red, green, blue} !== 15'd0 || rom_address !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b opaque=%b rgb=%h addr=%0d expected all 0",
                     busy, done, opaque, {red, green, blue}, rom_address);
        end
        reset_n = 1'b1;
        @(negedge vga_clk);
    endtask

    task automatic test_basic();
        write_pal(5, 12'hF80);
        for (int i = 1; i < 2**IDX_W; i++) if (i != 5) write_pal(i, 12'($urandom));
        write_pal(0, 12'hFFF);
        frame_pulse(100, 50, 1'b0);
        add_pt(100, 50, 1'b1);
        run_queue("basic");
    endtask

    task automatic test_flip();
        frame_pulse(100, 50, 1'b1);
        add_pt(100, 50, 1'b1);
        add_pt(163, 51, 1'b1);
        add_pt(131, 140, 1'b1);
        run_queue("flip");
    endtask

    task automatic test_bounds();
        frame_pulse(100, 50, 1'b0);
        add_pt(99, 50, 1'b1);
        add_pt(164, 50, 1'b1);
        add_pt(100, 146, 1'b1);
        add_pt(100, 49, 1'b1);
        add_pt(163, 145, 1'b1);
        add_pt(105, 50, 1'b1);
        add_pt(100, 50, 1'b0);
        add_pt(0, 0, 1'b1);
        for (int i = 0; i < 40; i++)
            add_pt(98 + $urandom_range(0, SPR_W + 3), 48 + $urandom_range(0, SPR_H + 3), ($urandom_range(0, 3) != 0));
        run_queue("bounds");
    endtask

    task automatic test_loop();
        do_play(1'b1, 1'b0);
        check_origin("loop_f");
        for (int p = 0; p < FRAMES*HOLD + 2; p++) begin
            frame_pulse(m_sx, m_sy, 1'b0);
            check_origin("loop_f");
        end
    endtask

    task automatic test_oneshot();
        do_play(1'b0, 1'b0);
        for (int p = 0; p < FRAMES*HOLD; p++) frame_pulse(m_sx, m_sy, 1'b0);
        check_origin("oneshot_end");
        frame_pulse(m_sx, m_sy, 1'b0);
        check_origin("oneshot_after");
    endtask

    task automatic test_play_fs();
        do_play(1'b1, 1'b0);
        for (int p = 0; p < 8; p++) frame_pulse(m_sx, m_sy, 1'b0);
        do_play(1'b1, 1'b1);
        check_origin("playfs_f0");
        for (int p = 0; p < HOLD; p++) begin
            frame_pulse(m_sx, m_sy, 1'b0);
            check_origin("playfs_hold");
        end
    endtask

    task automatic test_pal_hazard();
        logic [11:0] old_c, new_c;
        frame_pulse(100, 50, 1'b0);
        old_c = m_pal[5];
        new_c = 12'h0AB;
        for (int i = 0; i < 6; i++) begin
            @(negedge vga_clk);
            if (i == 3) begin
                n_vec++;
                if ({opaque, red, green, blue} !== {1'b1, old_c}) begin
                    n_err++;
                    $display("FAIL pal_old: got %h expected %h", {opaque, red, green, blue}, {1'b1, old_c});
                end
            end
            if (i == 4) begin
                n_vec++;
                if ({opaque, red, green, blue} !== {1'b1, new_c}) begin
                    n_err++;
                    $display("FAIL pal_new: got %h expected %h", {opaque, red, green, blue}, {1'b1, new_c});
                end
            end
            draw_x = 10'd100;
            draw_y = 10'd50;
            blank  = (i < 2);
            pal_we = (i == 2);
            pal_windex = 3'd5;
            pal_wdata = new_c;
        end
        pal_we = 1'b0;
        m_pal[5] = new_c;
    endtask

    task automatic test_random();
        int x, y;
        for (int r = 0; r < 6; r++) begin
            write_pal($urandom_range(0, 2**IDX_W - 1), 12'($urandom));
            write_pal($urandom_range(0, 2**IDX_W - 1), 12'($urandom));
            if (r == 2) do_play(1'b1, 1'b0);
            frame_pulse($urandom_range(0, 900), $urandom_range(0, 600), 1'($urandom));
            for (int i = 0; i < 30; i++) begin
                x = m_sx - 2 + $urandom_range(0, SPR_W + 3);
                y = m_sy - 2 + $urandom_range(0, SPR_H + 3);
                if (x < 0) x = 0;
                if (x > 1023) x = 1023;
                if (y < 0) y = 0;
                if (y > 1023) y = 1023;
                add_pt(x, y, ($urandom_range(0, 3) != 0));
            end
            run_queue("random");
        end
    endtask

    task automatic test_reset_mid();
        logic [12:0] exp_p;
        write_pal(5, 12'hF80);
        frame_pulse(100, 50, 1'b0);
        do_play(1'b1, 1'b0);
        exp_p = exp_pix(100, 50, 1'b1);
        @(negedge vga_clk);
        draw_x = 10'd100;
        draw_y = 10'd50;
        blank  = 1'b1;
        repeat (3) @(negedge vga_clk);
        n_vec++;
        if ({opaque, red, green, blue} !== exp_p || busy !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: got pix=%h busy=%b expected pix=%h busy=1", {opaque, red, green, blue}, busy, exp_p);
        end
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, opaque, red, green, blue} !== 15'd0 || rom_address !== '0) begin
            n_err++;
            $display("FAIL async_reset: got busy=%b done=%b pix=%h addr=%0d expected all 0",
                     busy, done, {opaque, red, green, blue}, rom_address);
        end
        @(negedge vga_clk);
        reset_n = 1'b1;
        blank = 1'b0;
        for (int i = 0; i < 2**IDX_W; i++) m_pal[i] = '0;
        m_sx = 0;
        m_sy = 0;
        m_flip = 0;
        m_played = 0;
        m_pulses = 0;
        m_loop = 0;
        add_pt(0, 0, 1'b1);
        add_pt(10, 20, 1'b1);
        run_queue("post_reset");
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_fsm: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    initial begin
        for (int i = 0; i < FRAMES*FSZ; i++) rom_mem[i] = IDX_W'($urandom);
        for (int f = 0; f < FRAMES; f++) rom_mem[f*FSZ] = 3'd5;
        rom_mem[5] = '0;
        for (int i = 0; i < 2**IDX_W; i++) m_pal[i] = '0;
        test_reset();
        test_basic();
        test_flip();
        test_bounds();
        test_loop();
        test_oneshot();
        test_play_fs();
        test_pal_hazard();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
